wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Write-back stage of the 5-stage MIPS pipeline, directly downstream of the MEM stage.
- Consists of:
  - MEM/WB pipeline register, with stall and flush.
  - MemtoReg write-back mux.
  - 32x32 register file: two read ports serving ID, one write port driven by this stage.
  - Retired-write counter.
- Exports the write-back bus (RegWrite/WriteReg/WriteData) for the forwarding unit.

Parameters:
- DATA_W, 32, datapath and register width.
- REG_AW, 5, register address width (2**REG_AW registers).
- CNT_W, 32, retire counter width.

Ports:
- Clk  in  1  rising-edge clock.
- Rst_n  in  1  asynchronous active-low reset.
- WB  in  2  control from MEM: bit1 = RegWrite, bit0 = MemtoReg.
- ReadData  in  DATA_W  data-memory load result.
- AluResult  in  DATA_W  ALU result passed through MEM.
- WriteReg  in  REG_AW  destination register.
- Stall  in  1  hold the MEM/WB register contents.
- Flush  in  1  load a bubble into the MEM/WB register.
- ReadReg1  in  REG_AW  ID read address, port 1.
- ReadReg2  in  REG_AW  ID read address, port 2.
- ReadData1  out  DATA_W  register file read data, port 1 (combinational).
- ReadData2  out  DATA_W  register file read data, port 2 (combinational).
- WB_RegWrite  out  1  registered RegWrite, qualified by pending (see Behaviour).
- WB_WriteReg  out  REG_AW  registered destination register.
- WB_WriteData  out  DATA_W  mux output: MemtoReg ? ReadData_q : AluResult_q.
- RetireCount  out  CNT_W  number of committed register writes.

Behaviour:
- Reset (Rst_n=0, asynchronous):
  - All MEM/WB fields cleared; pending cleared.
  - All 32 registers cleared.
  - RetireCount=0.
  - Outputs after reset: WB_RegWrite=0, WB_WriteReg=0, WB_WriteData=0, ReadData1/2=0.
  - Reset asserted mid-operation discards the in-flight entry; no write is committed.
- Pipeline register, at each posedge with Rst_n=1. Priority Flush > Stall > load:
  - Flush: WB_q=0, pending=0. Data fields are don't-care but are cleared.
  - Stall (no Flush): all fields held.
  - Otherwise: capture WB, ReadData, AluResult, WriteReg; pending=1.
- Commit:
  - Condition: pending & RegWrite_q & (WriteReg_q != 0).
  - Effect at the next posedge: regfile[WriteReg_q] <= WB_WriteData, RetireCount += 1, pending <= 0.
  - An entry captured at edge N commits at edge N+1. The stage-to-register-file latency is 2 edges from MEM input.
- Stall on a held entry:
  - Commits at most once; pending clears after the first commit.
  - No double write, no double count.
  - On the same edge, a Stall with an uncommitted entry still commits.
- WB_RegWrite = RegWrite_q & pending & (WriteReg_q != 0).
  - Forwarding sees a write only until it is committed.
  - Writes to $0 never appear on the bus.
- Register $0:
  - Always reads 0.
  - Writes to it are dropped and not counted.
- Read ports:
  - Combinational from the array.
  - ReadReg=0 always returns 0.
- Simultaneous commit and Flush on one edge: the commit of the old entry completes, and the bubble loads.
- RetireCount wraps modulo 2**CNT_W with no saturation. 0xFFFFFFFF -> 0.
- The write-back mux uses registered values only; inputs take no combinational path to WB_WriteData.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined:
  - When a commit is pending this cycle and ReadRegN == WriteReg_q (nonzero), ReadDataN returns WB_WriteData.
  - Gives write-then-read in the same cycle without a split-phase register file.
- Undefined:
  - ReadDataN returns the array contents, i.e. the old value, until the commit edge.
  - The hazard unit must cover the one-cycle gap.

Test Plan:
- Reset then ALU write: WB=2'b10, AluResult=0x0000_1234, WriteReg=5.
  - Edge 1: WB_RegWrite=1, WB_WriteData=0x1234.
  - Edge 2: ReadReg1=5 -> 0x1234, RetireCount=1, WB_RegWrite=0.
- Load write: WB=2'b11, ReadData=0xDEAD_BEEF, AluResult=0x40, WriteReg=9 -> WB_WriteData=0xDEADBEEF; after commit, reg9=0xDEADBEEF.
- $0 write: WB=2'b10, WriteReg=0, AluResult=0xFFFF_FFFF -> WB_RegWrite=0, ReadReg2=0 reads 0, RetireCount unchanged.
- Stall: load entry (WriteReg=3, data 0x77), then hold Stall=1 for 4 cycles -> reg3=0x77, RetireCount increments exactly 1.
  - Flush alongside Stall -> bubble loaded, no further commits.
- Bypass: commit pending to reg 7 with value 0xA5A5_A5A5, ReadReg1=7 in the same cycle.
  - WB_BYPASS_EN defined -> 0xA5A5A5A5.
  - Undefined -> prior value (0 after reset).
- Async reset mid-pipe: entry pending to reg 4, Rst_n low between edges -> outputs 0 immediately; after release, reg4=0 and RetireCount=0.

Source files
------------

// File: rtl/wb_stage.sv
// MIPS write-back stage: MEM/WB register, MemtoReg mux, 32-entry register file, retire counter.
// Optional macro WB_BYPASS_EN forwards the pending commit value onto the read ports.
module wb_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [1:0]        WB,
  input  logic [DATA_W-1:0] ReadData,
  input  logic [DATA_W-1:0] AluResult,
  input  logic [REG_AW-1:0] WriteReg,
  input  logic              Stall,
  input  logic              Flush,
  input  logic [REG_AW-1:0] ReadReg1,
  input  logic [REG_AW-1:0] ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic              WB_RegWrite,
  output logic [REG_AW-1:0] WB_WriteReg,
  output logic [DATA_W-1:0] WB_WriteData,
  output logic [CNT_W-1:0]  RetireCount
);
  localparam int NREG = 1 << REG_AW;

  logic [1:0]        wb_q, wb_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [REG_AW-1:0] wreg_q, wreg_d;
  logic              pending_q, pending_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] regs_q [NREG];
  logic              commit;
  logic [DATA_W-1:0] wdata;

  // pending marks an entry that has not yet been committed; it stops a stalled entry writing twice
  assign commit       = pending_q & wb_q[1] & (wreg_q != '0);
  assign wdata        = wb_q[0] ? rd_q : alu_q;
  assign WB_RegWrite  = commit;
  assign WB_WriteReg  = wreg_q;
  assign WB_WriteData = wdata;
  assign RetireCount  = cnt_q;

  always_comb begin
    wb_d      = wb_q;
    rd_d      = rd_q;
    alu_d     = alu_q;
    wreg_d    = wreg_q;
    pending_d = pending_q & ~commit;
    cnt_d     = commit ? cnt_q + CNT_W'(1) : cnt_q;
    if (Flush) begin
      wb_d      = '0;
      rd_d      = '0;
      alu_d     = '0;
      wreg_d    = '0;
      pending_d = 1'b0;
    end else if (!Stall) begin
      wb_d      = WB;
      rd_d      = ReadData;
      alu_d     = AluResult;
      wreg_d    = WriteReg;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wb_q      <= '0;
      rd_q      <= '0;
      alu_q     <= '0;
      wreg_q    <= '0;
      pending_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      wb_q      <= wb_d;
      rd_q      <= rd_d;
      alu_q     <= alu_d;
      wreg_q    <= wreg_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (commit) begin
      regs_q[wreg_q] <= wdata;
    end
  end

  always_comb begin
    ReadData1 = (ReadReg1 == '0) ? '0 : regs_q[ReadReg1];
    ReadData2 = (ReadReg2 == '0) ? '0 : regs_q[ReadReg2];
`ifdef WB_BYPASS_EN
    if (commit && ReadReg1 == wreg_q) ReadData1 = wdata;
    if (commit && ReadReg2 == wreg_q) ReadData2 = wdata;
`else
    // no bypass: readers see the old value until the commit edge
`endif
  end
endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: driver predicts post-edge outputs from a register-file model,
// a monitor compares them one time step after every rising edge.
module tb_wb_stage;
  localparam int CNT_W = 4;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b1;
  logic [1:0]  WB = '0;
  logic [31:0] ReadData = '0, AluResult = '0;
  logic [4:0]  WriteReg = '0, ReadReg1 = '0, ReadReg2 = '0;
  logic        Stall = 1'b0, Flush = 1'b0;
  logic [31:0] ReadData1, ReadData2, WB_WriteData;
  logic        WB_RegWrite;
  logic [4:0]  WB_WriteReg;
  logic [CNT_W-1:0] RetireCount;

  wb_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .WB(WB), .ReadData(ReadData), .AluResult(AluResult),
    .WriteReg(WriteReg), .Stall(Stall), .Flush(Flush), .ReadReg1(ReadReg1),
    .ReadReg2(ReadReg2), .ReadData1(ReadData1), .ReadData2(ReadData2),
    .WB_RegWrite(WB_RegWrite), .WB_WriteReg(WB_WriteReg), .WB_WriteData(WB_WriteData),
    .RetireCount(RetireCount)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic        rw;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [31:0] cnt;
    logic [31:0] r1;
    logic [31:0] r2;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: architectural registers plus the one in-flight instruction.
  logic [31:0] m_regs [32];
  logic        e_valid, e_regwrite, e_memtoreg;
  logic [31:0] e_load, e_alu;
  logic [4:0]  e_dest;
  int          m_retired;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] model_result();
    return e_memtoreg ? e_load : e_alu;
  endfunction

  function automatic bit model_writes();
    return e_valid && e_regwrite && e_dest != 0;
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] r);
    if (r == 0) return 32'h0;
`ifdef WB_BYPASS_EN
    if (model_writes() && r == e_dest) return model_result();
`endif
    return m_regs[r];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    e_valid = 0; e_regwrite = 0; e_memtoreg = 0;
    e_load = 0; e_alu = 0; e_dest = 0;
    m_retired = 0;
  endtask

  task automatic set_and_predict(input logic [1:0] wb, input logic [31:0] ld, input logic [31:0] alu,
                                 input logic [4:0] dst, input logic st, input logic fl,
                                 input logic [4:0] r1, input logic [4:0] r2);
    exp_t e;
    WB = wb; ReadData = ld; AluResult = alu; WriteReg = dst;
    Stall = st; Flush = fl; ReadReg1 = r1; ReadReg2 = r2;
    // the instruction in WB retires once, then the next one arrives (or a bubble / nothing)
    if (model_writes()) begin
      m_regs[e_dest] = model_result();
      m_retired = (m_retired + 1) % (1 << CNT_W);
      e_valid = 0;
    end
    if (fl) begin
      e_valid = 0; e_regwrite = 0; e_memtoreg = 0; e_load = 0; e_alu = 0; e_dest = 0;
    end else if (!st) begin
      e_valid = 1; e_regwrite = wb[1]; e_memtoreg = wb[0]; e_load = ld; e_alu = alu; e_dest = dst;
    end
    e.rw  = model_writes();
    e.wr  = e_dest;
    e.wd  = model_result();
    e.cnt = 32'(m_retired);
    e.r1  = model_read(r1);
    e.r2  = model_read(r2);
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [1:0] wb, input logic [31:0] ld, input logic [31:0] alu,
                       input logic [4:0] dst, input logic st, input logic fl,
                       input logic [4:0] r1, input logic [4:0] r2);
    @(negedge Clk);
    set_and_predict(wb, ld, alu, dst, st, fl, r1, r2);
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
    drive(2'b00, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, r1, r2);
  endtask

  // Reset pulse strictly between two rising edges; outputs must clear at once.
  task automatic reset_pulse();
    @(negedge Clk);
    #1 Rst_n = 1'b0;
    ReadReg1 = 5'd4; ReadReg2 = 5'd9;
    #1;
    chk("rst_regwrite", 32'(WB_RegWrite), 32'h0);
    chk("rst_writereg", 32'(WB_WriteReg), 32'h0);
    chk("rst_writedata", WB_WriteData, 32'h0);
    chk("rst_count", 32'(RetireCount), 32'h0);
    chk("rst_rd1", ReadData1, 32'h0);
    chk("rst_rd2", ReadData2, 32'h0);
    model_reset();
    #1 Rst_n = 1'b1;
    set_and_predict(2'b00, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1, 5'd4, 5'd9);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("wb_regwrite", 32'(WB_RegWrite), 32'(e.rw));
        chk("wb_writereg", 32'(WB_WriteReg), 32'(e.wr));
        chk("wb_writedata", WB_WriteData, e.wd);
        chk("retire_count", 32'(RetireCount), e.cnt);
        chk("read_data1", ReadData1, e.r1);
        chk("read_data2", ReadData2, e.r2);
      end
    end
  end

  initial begin : stimulus
    model_reset();
    reset_pulse();
    // ALU write to $5, then commit
    drive(2'b10, 32'h0, 32'h0000_1234, 5'd5, 0, 0, 5'd5, 5'd0);
    idle(5'd5, 5'd0);
    // load write to $9
    drive(2'b11, 32'hDEAD_BEEF, 32'h40, 5'd9, 0, 0, 5'd9, 5'd5);
    idle(5'd9, 5'd5);
    // write to $0 is dropped
    drive(2'b10, 32'h0, 32'hFFFF_FFFF, 5'd0, 0, 0, 5'd5, 5'd0);
    idle(5'd9, 5'd0);
    // stalled entry commits once, then Flush+Stall loads a bubble
    drive(2'b10, 32'h0, 32'h77, 5'd3, 0, 0, 5'd3, 5'd5);
    for (int i = 0; i < 4; i++) drive(2'b10, 32'h0, 32'hBAD, 5'd6, 1, 0, 5'd3, 5'd6);
    drive(2'b10, 32'h0, 32'hBAD, 5'd6, 1, 1, 5'd3, 5'd6);
    idle(5'd3, 5'd6);
    // same-cycle read of the register being committed
    drive(2'b10, 32'h0, 32'hA5A5_A5A5, 5'd7, 0, 0, 5'd7, 5'd7);
    idle(5'd7, 5'd3);
    // reset while an entry to $4 is pending
    drive(2'b10, 32'h0, 32'h4444, 5'd4, 0, 0, 5'd4, 5'd0);
    reset_pulse();
    idle(5'd4, 5'd9);
    // randomized traffic with small register range to force collisions and counter wrap
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) reset_pulse();
      else drive(2'($urandom_range(0, 3)), $urandom, $urandom, 5'($urandom_range(0, 7)),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    idle(5'd1, 5'd2);
    repeat (3) @(negedge Clk);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
